// File: rtl/noc_ni_pkg.sv
// Shared definitions for the network-interface injection stage: flit-type
// codes, the handshake FSM state encoding and the 1-of-4 symbol encoder.
package noc_ni_pkg;

  localparam logic [2:0] FT_HEAD = 3'b001;
  localparam logic [2:0] FT_DATA = 3'b010;
  localparam logic [2:0] FT_TAIL = 3'b100;

  // Four-phase handshake: idle/accepting, request held, return-to-zero.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RTZ  = 2'd2
  } ni_state_e;

  // A 2-bit pair maps to a single hot rail: value v raises rail v.
  function automatic logic [3:0] enc14(input logic [1:0] i_pair);
    return 4'b0001 << i_pair;
  endfunction

endpackage

// File: rtl/ni_sync.sv
// Two-flop synchronizer that brings an asynchronous handshake wire from the
// router into the clk domain. Both stages clear on reset.
module ni_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the asynchronous input through two stages; the first may go
  // metastable, the second is what the rest of the design looks at.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/ni_local_tx.sv
// Synchronous-to-QDI injection stage. Binary flits from the core are encoded
// into 1-of-4 rails, driven to the router with a four-phase return-to-zero
// handshake against lia, and gated by per-VC credits returned on lic/lica.
module ni_local_tx
  import noc_ni_pkg::*;
#(
  parameter int VCN = 1,
  parameter int DW  = 32,
  parameter int FT  = 3,
  parameter int SCN = DW / 2,
  parameter int CRD = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DW-1:0]                   in_data,
  input  logic [FT-1:0]                   in_ft,
  input  logic [VCN-1:0]                  in_vc,
  output logic [SCN-1:0]                  li0,
  output logic [SCN-1:0]                  li1,
  output logic [SCN-1:0]                  li2,
  output logic [SCN-1:0]                  li3,
  output logic [FT-1:0]                   lift,
  output logic [VCN-1:0]                  livc,
  input  logic                            lia,
  input  logic [VCN-1:0]                  lic,
  output logic [VCN-1:0]                  lica,
  output logic [VCN*$clog2(CRD+1)-1:0]    crd
);

  localparam int CW = $clog2(CRD + 1);
  localparam logic [VCN-1:0] VC_ONE  = VCN'(1);
  localparam logic [CW-1:0]  CRD_MAX = CW'(CRD);
  localparam logic [CW-1:0]  CRD_ONE = CW'(1);

  ni_state_e r_state;
  ni_state_e w_stateNext;

  logic           w_ackS;
  logic [VCN-1:0] w_crS;

  logic [SCN-1:0] r_li0;
  logic [SCN-1:0] r_li1;
  logic [SCN-1:0] r_li2;
  logic [SCN-1:0] r_li3;
  logic [FT-1:0]  r_lift;
  logic [VCN-1:0] r_livc;
  logic [VCN-1:0] r_lica;
  logic [CW-1:0]  r_credit [VCN];

  logic [SCN-1:0] w_enc0;
  logic [SCN-1:0] w_enc1;
  logic [SCN-1:0] w_enc2;
  logic [SCN-1:0] w_enc3;

  logic           w_vcOneHot;
  logic           w_crdAvail;
  logic           w_accept;
  logic           w_clearRails;
  logic [VCN-1:0] w_crNonZero;
  logic [VCN-1:0] w_crRise;
  logic [VCN-1:0] w_crFall;
  logic [VCN-1:0] w_dec;

  // Synchronizers for the router's data ack and each credit request.
  ni_sync u_syncAck (
    .clk (clk),
    .rst (rst),
    .i_d (lia),
    .o_q (w_ackS)
  );

  for (genvar gv = 0; gv < VCN; gv++) begin : g_crSync
    ni_sync u_syncCr (
      .clk (clk),
      .rst (rst),
      .i_d (lic[gv]),
      .o_q (w_crS[gv])
    );
  end

  // Encode every 2-bit pair of the payload into its 1-of-4 rail slice.
  always_comb begin
    logic [3:0] sym;
    w_enc0 = '0;
    w_enc1 = '0;
    w_enc2 = '0;
    w_enc3 = '0;
    for (int k = 0; k < SCN; k++) begin
      sym       = enc14(in_data[2*k +: 2]);
      w_enc0[k] = sym[0];
      w_enc1[k] = sym[1];
      w_enc2[k] = sym[2];
      w_enc3[k] = sym[3];
    end
  end

  // Decide whether the requested VC is legal and has a credit left. A zero
  // or multi-hot in_vc never qualifies, so such a flit is never accepted.
  always_comb begin
    w_vcOneHot = (in_vc != '0) && ((in_vc & (in_vc - VC_ONE)) == '0);
    for (int v = 0; v < VCN; v++) begin
      w_crNonZero[v] = (r_credit[v] != '0);
    end
    w_crdAvail = |(in_vc & w_crNonZero);
  end

  // Handshake next-state and control. in_ready is only offered from IDLE
  // once the previous ack has fully returned to zero.
  always_comb begin
    w_stateNext  = r_state;
    in_ready     = 1'b0;
    w_accept     = 1'b0;
    w_clearRails = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = !rst && !w_ackS && w_vcOneHot && w_crdAvail;
        w_accept = in_ready && in_valid;
        if (w_accept) begin
          w_stateNext = ST_REQ;
        end
      end
      ST_REQ: begin
        if (w_ackS) begin
          w_clearRails = 1'b1;
          w_stateNext  = ST_RTZ;
        end
      end
      ST_RTZ: begin
        if (!w_ackS) begin
          w_stateNext = ST_IDLE;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Rail registers: capture the encoded flit on accept, hold it through the
  // request phase and drop everything to zero once the router acks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_li0  <= '0;
      r_li1  <= '0;
      r_li2  <= '0;
      r_li3  <= '0;
      r_lift <= '0;
      r_livc <= '0;
    end else if (w_accept) begin
      r_li0  <= w_enc0;
      r_li1  <= w_enc1;
      r_li2  <= w_enc2;
      r_li3  <= w_enc3;
      r_lift <= in_ft;
      r_livc <= in_vc;
    end else if (w_clearRails) begin
      r_li0  <= '0;
      r_li1  <= '0;
      r_li2  <= '0;
      r_li3  <= '0;
      r_lift <= '0;
      r_livc <= '0;
    end
  end

  // Credit edges. lica mirrors the last credit level we acted on, so it
  // doubles as the edge-detect history: a held-high request counts once.
  always_comb begin
    w_crRise = w_crS & ~r_lica;
    w_crFall = ~w_crS & r_lica;
    w_dec    = {VCN{w_accept}} & in_vc;
  end

  // Credit acknowledge: raise on a request rise, drop on its fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lica <= '0;
    end else begin
      r_lica <= (r_lica | w_crRise) & ~w_crFall;
    end
  end

  // Per-VC credit counters. A simultaneous return and spend cancel out;
  // returns beyond the buffer depth are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VCN; v++) begin
        r_credit[v] <= CRD_MAX;
      end
    end else begin
      for (int v = 0; v < VCN; v++) begin
        if (w_crRise[v] && !w_dec[v] && (r_credit[v] != CRD_MAX)) begin
          r_credit[v] <= r_credit[v] + CRD_ONE;
        end else if (w_dec[v] && !w_crRise[v]) begin
          r_credit[v] <= r_credit[v] - CRD_ONE;
        end
      end
    end
  end

  for (genvar gv = 0; gv < VCN; gv++) begin : g_crdOut
    assign crd[gv*CW +: CW] = r_credit[gv];
  end

  assign li0  = r_li0;
  assign li1  = r_li1;
  assign li2  = r_li2;
  assign li3  = r_li3;
  assign lift = r_lift;
  assign livc = r_livc;
  assign lica = r_lica;

endmodule

// File: tb/tb_ni_local_tx.sv
// Self-checking bench for ni_local_tx with two VCs. Accepted flits are
// predicted into a scoreboard and compared when the rails rise; credits and
// in_ready are checked against a simple counting model.
module tb_ni_local_tx;

  localparam int VCN = 2;
  localparam int DW  = 32;
  localparam int FT  = 3;
  localparam int SCN = 16;
  localparam int CRD = 4;
  localparam int CW  = 3;

  localparam logic [2:0] FT_HEAD = 3'b001;
  localparam logic [2:0] FT_DATA = 3'b010;
  localparam logic [2:0] FT_TAIL = 3'b100;

  typedef struct {
    logic [SCN-1:0] l0;
    logic [SCN-1:0] l1;
    logic [SCN-1:0] l2;
    logic [SCN-1:0] l3;
    logic [FT-1:0]  ft;
    logic [VCN-1:0] vc;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [DW-1:0]       in_data;
  logic [FT-1:0]       in_ft;
  logic [VCN-1:0]      in_vc;
  logic [SCN-1:0]      li0, li1, li2, li3;
  logic [FT-1:0]       lift;
  logic [VCN-1:0]      livc;
  logic                lia;
  logic [VCN-1:0]      lic;
  logic [VCN-1:0]      lica;
  logic [VCN*CW-1:0]   crd;

  logic ackAuto;
  logic liaForce;
  logic railsAny;

  int   vectors = 0;
  int   miscompares = 0;
  int   acceptCount = 0;
  int   flitsSeen = 0;
  int   cyc = 0;
  int   lastAcceptCyc = 0;
  int   mCrd [VCN];
  exp_t sbQ [$];
  exp_t monE;
  logic prevRails = 1'b0;

  ni_local_tx #(
    .VCN (VCN),
    .DW  (DW),
    .FT  (FT),
    .SCN (SCN),
    .CRD (CRD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ft    (in_ft),
    .in_vc    (in_vc),
    .li0      (li0),
    .li1      (li1),
    .li2      (li2),
    .li3      (li3),
    .lift     (lift),
    .livc     (livc),
    .lia      (lia),
    .lic      (lic),
    .lica     (lica),
    .crd      (crd)
  );

  always #5 clk = ~clk;

  // Zero-delay router responder: acks while any rail is up, unless a test
  // takes manual control of lia.
  assign railsAny = |{li0, li1, li2, li3};
  assign lia      = ackAuto ? railsAny : liaForce;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected rails straight from the encoding rule: pair value v lights li<v>.
  function automatic exp_t expectFlit(input logic [DW-1:0] d, input logic [FT-1:0] ft,
                                      input logic [VCN-1:0] vc);
    exp_t e;
    e.l0 = '0; e.l1 = '0; e.l2 = '0; e.l3 = '0;
    for (int k = 0; k < SCN; k++) begin
      case ((d >> (2 * k)) & 32'h3)
        0: e.l0[k] = 1'b1;
        1: e.l1[k] = 1'b1;
        2: e.l2[k] = 1'b1;
        default: e.l3[k] = 1'b1;
      endcase
    end
    e.ft = ft;
    e.vc = vc;
    return e;
  endfunction

  function automatic logic [VCN*CW-1:0] packCrd();
    return {3'(mCrd[1]), 3'(mCrd[0])};
  endfunction

  // Record every accepted flit and queue its predicted rail image.
  always @(posedge clk) begin
    cyc++;
    if (!rst && in_valid && in_ready) begin
      sbQ.push_back(expectFlit(in_data, in_ft, in_vc));
      acceptCount++;
      lastAcceptCyc = cyc;
    end
  end

  // Monitor: when the rails rise from all-zero, a new flit is presented.
  always @(negedge clk) begin
    if (railsAny && !prevRails) begin
      flitsSeen++;
      if (sbQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_flit: got rails %0h expected none", {li3, li2, li1, li0});
      end else begin
        monE = sbQ.pop_front();
        checkOutput("flit_rails", {li3, li2, li1, li0}, {monE.l3, monE.l2, monE.l1, monE.l0});
        checkOutput("flit_ft_vc", {lift, livc}, {monE.ft, monE.vc});
      end
    end
    prevRails = railsAny;
  end

  // Offer one flit and wait (bounded) for it to be taken; returns on the
  // falling edge right after the accepting edge.
  task automatic applyStimulus(input logic [DW-1:0] d, input logic [FT-1:0] ft,
                               input logic [VCN-1:0] vc, input int budget);
    int start;
    bit done;
    int vi;
    in_data  = d;
    in_ft    = ft;
    in_vc    = vc;
    in_valid = 1'b1;
    start    = acceptCount;
    done     = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (acceptCount != start) done = 1'b1;
    end
    in_valid = 1'b0;
    vi = vc[1] ? 1 : 0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: got no accept expected accept on vc %0b", vc);
    end else begin
      mCrd[vi]--;
      checkOutput("crd_after_accept", crd, packCrd());
    end
  endtask

  // One full credit request/ack cycle on VC v with timing checks.
  task automatic pulseLic(input int v);
    lic[v] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("lica_early", lica[v], 1'b0);
    @(negedge clk);
    mCrd[v] = (mCrd[v] + 1 > CRD) ? CRD : mCrd[v] + 1;
    checkOutput("lica_rise", lica[v], 1'b1);
    checkOutput("crd_on_credit", crd, packCrd());
    lic[v] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("lica_hold", lica[v], 1'b1);
    @(negedge clk);
    checkOutput("lica_fall", lica[v], 1'b0);
  endtask

  // Line up a credit return and an accept on the same edge for VC v.
  task automatic simulAccept(input int v);
    int start;
    lic[v] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_data  = $urandom;
    in_ft    = FT_DATA;
    in_vc    = (v == 1) ? 2'b10 : 2'b01;
    start    = acceptCount;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("simul_accept", 64'(acceptCount - start), 64'd1);
    checkOutput("simul_crd", crd, packCrd());
    checkOutput("simul_lica", lica[v], 1'b1);
    lic[v] = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("simul_lica_fall", lica[v], 1'b0);
  endtask

  // Hold an illegal or unfunded request for a while and make sure nothing goes.
  task automatic expectBlocked(input string name, input logic [VCN-1:0] vc, input int cycles);
    int start;
    in_vc    = vc;
    in_data  = $urandom;
    in_valid = 1'b1;
    start    = acceptCount;
    repeat (cycles) @(negedge clk);
    checkOutput({name, "_ready"}, in_ready, 1'b0);
    checkOutput({name, "_noaccept"}, 64'(acceptCount - start), 64'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    int t0;
    int v;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_ft    = FT_HEAD;
    in_vc    = 2'b01;
    lic      = '0;
    ackAuto  = 1'b1;
    liaForce = 1'b0;
    mCrd[0]  = CRD;
    mCrd[1]  = CRD;

    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_rails", {li3, li2, li1, li0}, 64'd0);
    checkOutput("rst_ft_vc", {lift, livc}, 64'd0);
    checkOutput("rst_lica", lica, 64'd0);
    checkOutput("rst_crd", crd, packCrd());
    checkOutput("idle_in_ready", in_ready, 1'b1);

    // Head flit with data 1, then two more back-to-back to measure spacing.
    applyStimulus(32'h0000_0001, FT_HEAD, 2'b01, 20);
    checkOutput("head_li1", li1, 16'h0001);
    checkOutput("head_li0", li0, 16'hFFFE);
    checkOutput("head_lift", lift, FT_HEAD);
    t0 = lastAcceptCyc;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rails_held", railsAny, 1'b1);
    @(negedge clk);
    checkOutput("rails_cleared", railsAny, 1'b0);
    applyStimulus($urandom, FT_DATA, 2'b01, 20);
    checkOutput("flit_gap1", 64'(lastAcceptCyc - t0), 64'd7);
    t0 = lastAcceptCyc;
    applyStimulus($urandom, FT_TAIL, 2'b01, 20);
    checkOutput("flit_gap2", 64'(lastAcceptCyc - t0), 64'd7);

    // Exhaust VC0: the CRD-th flit goes, the next one is held off.
    applyStimulus($urandom, FT_HEAD, 2'b01, 20);
    expectBlocked("vc0_empty", 2'b01, 20);
    checkOutput("vc0_crd_zero", crd[CW-1:0], 64'd0);
    pulseLic(0);
    applyStimulus($urandom, FT_TAIL, 2'b01, 20);

    // Refill VC0 with one pulse more than needed to hit saturation.
    for (int i = 0; i < CRD + 1; i++) pulseLic(0);
    checkOutput("vc0_saturated", crd[CW-1:0], 64'(CRD));

    // Drain VC1 while VC0 is full, then probe VC selection.
    for (int i = 0; i < CRD; i++) applyStimulus($urandom, FT_DATA, 2'b10, 20);
    repeat (10) @(negedge clk);
    in_vc = 2'b10;
    #1 checkOutput("vc1_unfunded_ready", in_ready, 1'b0);
    in_vc = 2'b01;
    #1 checkOutput("vc0_funded_ready", in_ready, 1'b1);
    expectBlocked("vc_multi_hot", 2'b11, 15);
    expectBlocked("vc_zero", 2'b00, 15);
    for (int i = 0; i < CRD; i++) pulseLic(1);

    // Credit return coinciding with an accept on the same VC.
    applyStimulus($urandom, FT_HEAD, 2'b01, 20);
    repeat (10) @(negedge clk);
    simulAccept(0);
    repeat (10) @(negedge clk);

    // Reset while the request phase is held and the ack is still high.
    ackAuto  = 1'b0;
    liaForce = 1'b0;
    applyStimulus($urandom, FT_HEAD, 2'b10, 20);
    @(negedge clk);
    checkOutput("req_rails_up", railsAny, 1'b1);
    liaForce = 1'b1;
    rst      = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    mCrd[0] = CRD;
    mCrd[1] = CRD;
    checkOutput("midrst_rails", {li3, li2, li1, li0}, 64'd0);
    checkOutput("midrst_crd", crd, packCrd());
    checkOutput("midrst_lica", lica, 64'd0);
    in_vc = 2'b10;
    @(negedge clk);
    @(negedge clk);
    checkOutput("ack_blocks_ready", in_ready, 1'b0);
    liaForce = 1'b0;
    @(negedge clk);
    checkOutput("ack_still_blocks", in_ready, 1'b0);
    @(negedge clk);
    checkOutput("ack_released_ready", in_ready, 1'b1);
    ackAuto = 1'b1;

    // Randomized traffic over both VCs with sporadic credit returns.
    for (int i = 0; i < 40; i++) begin
      v = $urandom_range(0, 1);
      if (mCrd[v] == 0) pulseLic(v);
      if ($urandom_range(0, 3) == 0) pulseLic($urandom_range(0, 1));
      applyStimulus($urandom, 3'b001 << $urandom_range(0, 2),
                    (v == 1) ? 2'b10 : 2'b01, 30);
    end

    repeat (12) @(negedge clk);
    checkOutput("sb_drained", 64'(sbQ.size()), 64'd0);
    checkOutput("flits_seen", 64'(flitsSeen), 64'(acceptCount));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
